pdm_playback_ctrl: RTL and testbench
====================================

# pdm_playback_ctrl

Sequencing and arbitration controller for the PDM audio serializer. Two word-stream sources share the serializer. The controller prefetches one 32-bit PDM word from the granted source and presents it on the serializer's parallel input after every word-done pulse. It gates the serializer's output enable across a start/stop playback sequence, and substitutes a silence pattern when no word is ready (underrun).

## Interface
Parameters:
- C_NR_OF_BITS, 32: PDM word width; must match the serializer.
- C_NR_SRC, 2: number of requesting sources; fixed at 2 in this revision.
- C_SILENCE, 32'hAAAA_AAAA: 50 %-density word emitted on underrun and when idle.

Ports:
- clk_i, in, 1: system clock. One clock domain.
- rst_ni, in, 1: reset, asynchronous, active-low.
- start_i, in, 1: single-cycle request to begin playback.
- stop_i, in, 1: single-cycle request to end playback.
- busy_o, out, 1: high in any state other than IDLE.
- src_valid_i, in, C_NR_SRC: per-source word valid.
- src_data_i, in, C_NR_SRC*C_NR_OF_BITS: per-source word; source k occupies bits [k*32 +: 32].
- src_last_i, in, C_NR_SRC: marks the last word of a source burst.
- src_ready_o, out, C_NR_SRC: per-source ready. A transfer happens on valid & ready.
- grant_o, out, C_NR_SRC: one-hot current grant; all zero when no grant is held.
- ser_en_o, out, 1: drives the serializer enable.
- ser_done_i, in, 1: one-cycle word-done pulse from the serializer.
- ser_data_o, out, C_NR_OF_BITS: drives the serializer parallel data input.
- underrun_o, out, 1: one-cycle pulse on each underrun.
- underrun_cnt_o, out, 16: underrun count. Present only with the configuration macro.

## Operation
State machine: IDLE, PRIME, PLAY, DRAIN.
- IDLE:
  - Outputs: ser_en_o=0, src_ready_o=0, ser_data_o=C_SILENCE.
  - start_i → PRIME.
- PRIME:
  - Prefetch register (pf) accepts one word.
  - When pf fills → PLAY, with ser_en_o=1 from the next cycle.
  - stop_i → IDLE; pf is cleared.
- PLAY, on each ser_done_i:
  - If pf is full: ser_data_o ← pf and pf empties.
  - If pf is empty: ser_data_o ← C_SILENCE and underrun_o pulses.
  - stop_i → DRAIN.
- DRAIN:
  - src_ready_o=0.
  - On ser_done_i with pf full: move pf to ser_data_o as in PLAY.
  - On ser_done_i with pf empty: ser_data_o ← C_SILENCE, then → IDLE with ser_en_o=0.
  - start_i is ignored in DRAIN.
- Ready rule: src_ready_o[k] = grant_o[k] & ~pf_full & (state is PRIME or PLAY). Ready is combinational from registered state.
- Arbitration:
  - With no grant held, a round-robin choice is made among asserted src_valid_i. The source not served last wins a tie.
  - The grant locks from the first accepted word and is released in the cycle after a transfer with src_last_i=1.
  - A new grant may be issued in the same cycle the previous one releases. No idle cycle is inserted.
- Simultaneous events:
  - ser_done_i with pf empty in the same cycle as an accept: underrun is declared, and the accepted word lands in pf for the next done.
  - stop_i together with start_i: stop wins.
  - ser_done_i outside PLAY/DRAIN is ignored.

## Timing
- Reset values: busy_o=0, src_ready_o=0, grant_o=0, ser_en_o=0, ser_data_o=C_SILENCE, underrun_o=0, underrun_cnt_o=0. State is IDLE, pf is empty and the round-robin pointer is 0.
- ser_data_o is registered and updates on the clock edge after ser_done_i (1-cycle latency). The serializer reloads 31 PDM bit periods later, so this margin is ample.
- start_i → busy_o high after 1 cycle.
- Accept in cycle n → pf full from cycle n+1.
- underrun_o is registered and coincides with the ser_data_o update.
- Reset asserted mid-operation returns all state to reset values immediately. No drain occurs.

## Configuration
- PDM_UNDERRUN_CNT_EN defined:
  - underrun_cnt_o exists. It is a 16-bit counter that saturates at 16'hFFFF, increments on each underrun_o, and clears on start_i accepted in IDLE.
- Undefined:
  - The port and counter are absent.
  - underrun_o is still generated.

## Structure
- Package pdm_ctrl_pkg holds:
  - the state enum pdm_ctrl_state_t;
  - the constant PDM_SILENCE = 32'hAAAA_AAAA;
  - PDM_UNDERRUN_CNT_W = 16.
- Sub-module pdm_rr_arb: two-requester round-robin arbiter with lock and release-on-last. Inputs: req, accept, last. Outputs: one-hot grant.

## Test plan
- Reset: drive rst_ni low mid-PLAY → all outputs reach reset values; ser_data_o=32'hAAAA_AAAA.
- Single source: src0 sends 0x1234_5678, 0x0F0F_0F0F (last); start; pulse done 3× → ser_data_o is 0x1234_5678, then 0x0F0F_0F0F, then 0xAAAA_AAAA with underrun_o=1 once.
- Round-robin: both sources valid with 2-word bursts → grant order src0, src0, src1, src1, src0. No interleaving within a burst.
- Stop/drain: stop_i while pf is full → that word is emitted on the next done; after the following done the block is in IDLE, ser_en_o=0 and busy_o=0.
- Simultaneous: ser_done_i with pf empty and an accept in the same cycle → underrun pulse, and the accepted word appears on the next done.
- Macro: with PDM_UNDERRUN_CNT_EN, force 3 underruns → underrun_cnt_o=3. After restart the count is 0. Force 65540 underruns → the count holds at 16'hFFFF.

Source files
------------

// File: rtl/pdm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pdm_ctrl_pkg
// Shared types and constants for the PDM playback controller slice.
//   pdm_ctrl_state_t   : controller sequencing states
//   PDM_NR_OF_BITS     : PDM word width shared with the serializer
//   PDM_SILENCE        : 50 %-density word emitted on underrun and when idle
//   PDM_UNDERRUN_CNT_W : width of the optional underrun counter
// ---------------------------------------------------------------------------
package pdm_ctrl_pkg;

  localparam int          PDM_NR_OF_BITS     = 32;
  localparam logic [31:0] PDM_SILENCE        = 32'hAAAA_AAAA;
  localparam int          PDM_UNDERRUN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DRAIN = 2'd3
  } pdm_ctrl_state_t;

endpackage : pdm_ctrl_pkg

// File: rtl/pdm_playback_ctrl_if.sv
// ---------------------------------------------------------------------------
// pdm_playback_ctrl_if
// Word-stream bus between the audio sources and the playback controller.
//   src_valid : per-source word valid            (source -> controller)
//   src_data  : per-source word, source k at [k*C_NR_OF_BITS +: C_NR_OF_BITS]
//   src_last  : last word of a source burst      (source -> controller)
//   src_ready : per-source ready                 (controller -> source)
//   grant     : one-hot current grant            (controller -> source)
// Modports: master = source side, slave = controller side.
// ---------------------------------------------------------------------------
interface pdm_playback_ctrl_if #(
  parameter int C_NR_SRC     = 2,
  parameter int C_NR_OF_BITS = 32
);

  logic [C_NR_SRC-1:0]              src_valid;
  logic [C_NR_SRC*C_NR_OF_BITS-1:0] src_data;
  logic [C_NR_SRC-1:0]              src_last;
  logic [C_NR_SRC-1:0]              src_ready;
  logic [C_NR_SRC-1:0]              grant;

  modport master (output src_valid, src_data, src_last, input  src_ready, grant);
  modport slave  (input  src_valid, src_data, src_last, output src_ready, grant);

endinterface : pdm_playback_ctrl_if

// File: rtl/pdm_rr_arb.sv
// ---------------------------------------------------------------------------
// pdm_rr_arb
// Two-requester round-robin arbiter with burst lock.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req           : per-requester request (already qualified by the caller)
//   accept        : a word was transferred from the granted requester
//   last          : that transfer closed the burst
//   grant         : one-hot grant, zero when nothing is granted
// While unlocked the grant follows req; the first accepted non-last word
// locks it until the transfer carrying last, after which it is free again.
// ---------------------------------------------------------------------------
module pdm_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  input  logic       accept,
  input  logic       last,
  output logic [1:0] grant
);

  logic       lock_q, lock_d;
  logic [1:0] gnt_q, gnt_d;
  logic       prio_q, prio_d;   // requester that wins a tie
  logic [1:0] pick;

  always_comb begin
    pick = req;
    if (req == 2'b11) pick = prio_q ? 2'b10 : 2'b01;
  end

  assign grant = lock_q ? gnt_q : pick;

  always_comb begin
    lock_d = lock_q;
    gnt_d  = gnt_q;
    prio_d = prio_q;
    if (accept) begin
      // The requester just served loses the next tie.
      prio_d = grant[0];
      if (last) begin
        lock_d = 1'b0;
      end else begin
        lock_d = 1'b1;
        gnt_d  = grant;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
      gnt_q  <= 2'b00;
      prio_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      gnt_q  <= gnt_d;
      prio_q <= prio_d;
    end
  end

endmodule : pdm_rr_arb

// File: rtl/pdm_playback_ctrl.sv
// ---------------------------------------------------------------------------
// pdm_playback_ctrl
// Sequencing and arbitration controller in front of the PDM serializer.
// Prefetches one word from the granted source and hands it to the serializer
// on every word-done pulse; emits silence on underrun and while idle.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   start_i/stop_i : single-cycle playback start / stop (stop wins)
//   busy_o         : controller not in IDLE
//   src            : source word-stream bus (pdm_playback_ctrl_if.slave)
//   ser_en_o       : serializer enable (PLAY and DRAIN)
//   ser_done_i     : serializer word-done pulse
//   ser_data_o     : serializer parallel word, registered
//   underrun_o     : one-cycle pulse per underrun, aligned with ser_data_o
//   underrun_cnt_o : saturating underrun count, only with PDM_UNDERRUN_CNT_EN
// ---------------------------------------------------------------------------
module pdm_playback_ctrl
  import pdm_ctrl_pkg::*;
#(
  parameter int                      C_NR_OF_BITS = PDM_NR_OF_BITS,
  parameter int                      C_NR_SRC     = 2,
  parameter logic [C_NR_OF_BITS-1:0] C_SILENCE    = PDM_SILENCE
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    stop_i,
  output logic                    busy_o,
  pdm_playback_ctrl_if.slave      src,
  output logic                    ser_en_o,
  input  logic                    ser_done_i,
  output logic [C_NR_OF_BITS-1:0] ser_data_o,
  output logic                    underrun_o
`ifdef PDM_UNDERRUN_CNT_EN
  ,
  output logic [PDM_UNDERRUN_CNT_W-1:0] underrun_cnt_o
`endif
);

  pdm_ctrl_state_t         state_q, state_d;
  logic [C_NR_OF_BITS-1:0] pf_data_q, pf_data_d;
  logic                    pf_full_q, pf_full_d;
  logic [C_NR_OF_BITS-1:0] ser_data_q, ser_data_d;
  logic                    underrun_q, underrun_d;

  logic                    pf_open;
  logic [C_NR_SRC-1:0]     grant;
  logic [C_NR_SRC-1:0]     xfer;
  logic                    accept;
  logic                    acc_last;
  logic [C_NR_OF_BITS-1:0] acc_data;
  logic                    start_ok;

  // Sources may only be served while the prefetch slot is free and playing.
  assign pf_open  = ((state_q == ST_PRIME) || (state_q == ST_PLAY)) && !pf_full_q;
  assign xfer     = src.src_valid & src.src_ready;
  assign accept   = |xfer;
  assign acc_last = |(xfer & src.src_last);
  assign acc_data = grant[1] ? src.src_data[C_NR_OF_BITS +: C_NR_OF_BITS]
                             : src.src_data[0 +: C_NR_OF_BITS];
  assign start_ok = (state_q == ST_IDLE) && start_i && !stop_i;

  pdm_rr_arb u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (src.src_valid & {C_NR_SRC{pf_open}}),
    .accept (accept),
    .last   (acc_last),
    .grant  (grant)
  );

  assign src.grant     = grant;
  assign src.src_ready = grant & {C_NR_SRC{pf_open}};

  assign busy_o     = (state_q != ST_IDLE);
  assign ser_en_o   = (state_q == ST_PLAY) || (state_q == ST_DRAIN);
  assign ser_data_o = ser_data_q;
  assign underrun_o = underrun_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    pf_data_d  = pf_data_q;
    pf_full_d  = pf_full_q;
    ser_data_d = ser_data_q;
    underrun_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ser_data_d = C_SILENCE;
        if (start_ok) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (stop_i) begin
          state_d   = ST_IDLE;
          pf_full_d = 1'b0;
        end else if (accept) begin
          pf_data_d = acc_data;
          pf_full_d = 1'b1;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (ser_done_i) begin
          if (pf_full_q) begin
            ser_data_d = pf_data_q;
            pf_full_d  = 1'b0;
          end else begin
            ser_data_d = C_SILENCE;
            underrun_d = 1'b1;
          end
        end
        // An accept only happens with the slot empty, so it never collides
        // with the pop above; a same-cycle underrun keeps the new word.
        if (accept) begin
          pf_data_d = acc_data;
          pf_full_d = 1'b1;
        end
        if (stop_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ser_done_i) begin
          if (pf_full_q) begin
            ser_data_d = pf_data_q;
            pf_full_d  = 1'b0;
          end else begin
            ser_data_d = C_SILENCE;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      // NOTE: the prefetch data register is reset too, so no X can ever reach the serializer.
      pf_data_q  <= C_SILENCE;
      pf_full_q  <= 1'b0;
      ser_data_q <= C_SILENCE;
      underrun_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pf_data_q  <= pf_data_d;
      pf_full_q  <= pf_full_d;
      ser_data_q <= ser_data_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef PDM_UNDERRUN_CNT_EN
  logic [PDM_UNDERRUN_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (underrun_d && (cnt_q != {PDM_UNDERRUN_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + PDM_UNDERRUN_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign underrun_cnt_o = cnt_q;
`endif

endmodule : pdm_playback_ctrl

// File: tb/tb_pdm_playback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pdm_playback_ctrl
// Self-checking bench for pdm_playback_ctrl. A transaction-level reference
// model (playback phase, one-deep word buffer, burst owner, tie preference)
// predicts handshake signals every cycle and pushes the expected serializer
// word for each done pulse into a scoreboard queue; an independent monitor
// pops and compares the cycle after every done pulse.
// ---------------------------------------------------------------------------
module tb_pdm_playback_ctrl;
  import pdm_ctrl_pkg::*;

  localparam logic [31:0] SIL = 32'hAAAA_AAAA;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, stop_i, ser_done_i;
  logic        busy_o, ser_en_o, underrun_o;
  logic [31:0] ser_data_o;
`ifdef PDM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  pdm_playback_ctrl_if #(.C_NR_SRC(2), .C_NR_OF_BITS(32)) src_if ();

  pdm_playback_ctrl dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .busy_o     (busy_o),
    .src        (src_if),
    .ser_en_o   (ser_en_o),
    .ser_done_i (ser_done_i),
    .ser_data_o (ser_data_o),
    .underrun_o (underrun_o)
`ifdef PDM_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  typedef struct { logic [31:0] data; bit last; } beat_t;
  typedef struct { logic [31:0] data; bit ur;   } exp_t;
  typedef enum { M_IDLE, M_PRIME, M_PLAY, M_DRAIN } mphase_t;

  beat_t       src_q0[$], src_q1[$];
  logic [1:0]  vld;
  int          valid_prob;

  mphase_t     ph;
  logic [31:0] mbuf[$];
  int          owner, rr_next, mcnt;
  logic [31:0] last_out;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  int          acc_order[$];
  bit          done_prev, mon_en;
  int          n_cmp, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int k);
    return (k == 0) ? src_q0.size() : src_q1.size();
  endfunction

  function automatic beat_t q_front(input int k);
    beat_t b;
    b.data = 32'h0; b.last = 1'b0;
    if (k == 0 && src_q0.size() > 0) b = src_q0[0];
    if (k == 1 && src_q1.size() > 0) b = src_q1[0];
    return b;
  endfunction

  task automatic q_push(input int k, input logic [31:0] d, input bit l);
    beat_t b;
    b.data = d; b.last = l;
    if (k == 0) src_q0.push_back(b); else src_q1.push_back(b);
  endtask

  task automatic q_pop(input int k);
    if (k == 0) void'(src_q0.pop_front()); else void'(src_q1.pop_front());
  endtask

  function automatic logic [31:0] obs_at(input int i);
    return (obs_q.size() > i) ? obs_q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic int acc_at(input int i);
    return (acc_order.size() > i) ? acc_order[i] : -1;
  endfunction

  task automatic drive_src();
    beat_t b0, b1;
    b0 = q_front(0);
    b1 = q_front(1);
    src_if.src_valid = vld;
    src_if.src_data  = {b1.data, b0.data};
    src_if.src_last  = {b1.last & vld[1], b0.last & vld[0]};
  endtask

  // Monitor: the serializer word appears one cycle after each done pulse.
  always @(negedge clk_i) begin
    exp_t e;
    if (mon_en) begin
      if (done_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL scoreboard_empty: got word %0h, expected nothing queued", ser_data_o);
        end else begin
          e = exp_q.pop_front();
          obs_q.push_back(ser_data_o);
          check("ser_data", ser_data_o, e.data);
          check("underrun_pulse", underrun_o, e.ur);
        end
      end else begin
        check("underrun_quiet", underrun_o, 1'b0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    mon_en = 1'b0;
    rst_ni = 1'b0;
    start_i = 1'b0; stop_i = 1'b0; ser_done_i = 1'b0;
    src_q0.delete(); src_q1.delete();
    vld = 2'b00;
    drive_src();
    #2;
    check("rst_busy",     busy_o,           1'b0);
    check("rst_ready",    src_if.src_ready, 2'b00);
    check("rst_grant",    src_if.grant,     2'b00);
    check("rst_ser_en",   ser_en_o,         1'b0);
    check("rst_ser_data", ser_data_o,       SIL);
    check("rst_underrun", underrun_o,       1'b0);
`ifdef PDM_UNDERRUN_CNT_EN
    check("rst_cnt",      underrun_cnt_o,   16'h0);
`endif
    ph = M_IDLE; mbuf.delete(); owner = -1; rr_next = 0; mcnt = 0; last_out = SIL;
    exp_q.delete(); obs_q.delete(); acc_order.delete();
    done_prev = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    mon_en = 1'b1;
  endtask

  // One clock cycle: drive at negedge, predict/check at +1, advance model at posedge.
  task automatic cycle(input bit st, input bit sp, input bit dn);
    bit         can_take, m_acc, was_empty;
    int         g;
    beat_t      w;
    logic [1:0] exp_gnt, exp_rdy, rdy_s;
    exp_t       e;
    start_i = st; stop_i = sp; ser_done_i = dn;
    for (int k = 0; k < 2; k++)
      if (!vld[k] && q_size(k) > 0 && $urandom_range(99) < valid_prob) vld[k] = 1'b1;
    drive_src();
    #1;
    can_take = ((ph == M_PRIME) || (ph == M_PLAY)) && (mbuf.size() == 0);
    g = -1;
    if (owner >= 0)          g = owner;
    else if (can_take) begin
      if (vld == 2'b11)      g = rr_next;
      else if (vld[0])       g = 0;
      else if (vld[1])       g = 1;
    end
    exp_gnt = (g >= 0) ? (2'b01 << g) : 2'b00;
    exp_rdy = can_take ? exp_gnt : 2'b00;
    m_acc   = can_take && (g >= 0) && vld[g];
    w       = q_front((g >= 0) ? g : 0);
    check("src_ready", src_if.src_ready, exp_rdy);
    check("grant",     src_if.grant,     exp_gnt);
    check("busy",      busy_o,           ph != M_IDLE);
    check("ser_en",    ser_en_o,         (ph == M_PLAY) || (ph == M_DRAIN));
`ifdef PDM_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt_o, mcnt);
`endif
    rdy_s = src_if.src_ready;
    @(posedge clk_i);
    done_prev = dn;
    was_empty = (mbuf.size() == 0);
    if (dn) begin
      e.ur = 1'b0;
      if ((ph == M_PLAY || ph == M_DRAIN) && !was_empty) e.data = mbuf.pop_front();
      else if (ph == M_PLAY || ph == M_DRAIN) begin
        e.data = SIL;
        e.ur   = (ph == M_PLAY);
      end else e.data = last_out;
      if (e.ur && mcnt < 16'hFFFF) mcnt++;
      last_out = e.data;
      exp_q.push_back(e);
    end
    if (m_acc) begin
      rr_next = 1 - g;
      owner   = w.last ? -1 : g;
    end
    case (ph)
      M_IDLE:  if (st && !sp) begin ph = M_PRIME; mcnt = 0; end
      M_PRIME: if (sp) begin ph = M_IDLE; mbuf.delete(); end
               else if (m_acc) begin mbuf.push_back(w.data); ph = M_PLAY; end
      M_PLAY:  begin
                 if (m_acc) mbuf.push_back(w.data);
                 if (sp) ph = M_DRAIN;
               end
      M_DRAIN: if (dn && was_empty) ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
    for (int k = 0; k < 2; k++)
      if (vld[k] && rdy_s[k]) begin
        q_pop(k);
        vld[k] = 1'b0;
        acc_order.push_back(k);
      end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; valid_prob = 100; mon_en = 1'b0; done_prev = 1'b0;
    rst_ni = 1'b0; vld = 2'b00;
    do_reset();

    // Single source: two words then an underrun.
    q_push(0, 32'h1234_5678, 1'b0);
    q_push(0, 32'h0F0F_0F0F, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1); idle(2);
    cycle(1'b0, 1'b0, 1'b1); idle(2);
    cycle(1'b0, 1'b0, 1'b1); idle(2);
    check("single_cnt",   obs_q.size(), 3);
    check("single_word0", obs_at(0), 32'h1234_5678);
    check("single_word1", obs_at(1), 32'h0F0F_0F0F);
    check("single_word2", obs_at(2), SIL);

    // Reset mid-PLAY.
    do_reset();
    q_push(0, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    idle(2);
    do_reset();

    // Round-robin with 2-word bursts on both sources.
    q_push(0, 32'hA000_0000, 1'b0); q_push(0, 32'hA000_0001, 1'b1);
    q_push(0, 32'hC000_0000, 1'b0); q_push(0, 32'hC000_0001, 1'b1);
    q_push(1, 32'hB000_0000, 1'b0); q_push(1, 32'hB000_0001, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, (i % 3) == 2);
    check("rr_order0", acc_at(0), 0);
    check("rr_order1", acc_at(1), 0);
    check("rr_order2", acc_at(2), 1);
    check("rr_order3", acc_at(3), 1);
    check("rr_order4", acc_at(4), 0);

    // Stop while the prefetch slot is full, then drain.
    do_reset();
    q_push(0, 32'h5555_0001, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1); idle(1);
    cycle(1'b0, 1'b0, 1'b1); idle(2);
    check("drain_word",   obs_at(0), 32'h5555_0001);
    check("drain_sil",    obs_at(1), SIL);
    check("drain_busy",   busy_o,   1'b0);
    check("drain_ser_en", ser_en_o, 1'b0);

    // Underrun and accept in the same cycle.
    do_reset();
    q_push(0, 32'h0E0E_0000, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1); idle(1);
    q_push(0, 32'h0E0E_0001, 1'b1);
    cycle(1'b0, 1'b0, 1'b1); idle(1);
    cycle(1'b0, 1'b0, 1'b1); idle(2);
    check("simul_word0", obs_at(0), 32'h0E0E_0000);
    check("simul_sil",   obs_at(1), SIL);
    check("simul_word1", obs_at(2), 32'h0E0E_0001);

`ifdef PDM_UNDERRUN_CNT_EN
    // Underrun counter: three underruns, clear on restart, saturation.
    do_reset();
    q_push(0, 32'hF000_0000, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
    idle(1);
    check("cnt_three", underrun_cnt_o, 16'd3);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    idle(1);
    q_push(0, 32'hF000_0001, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    check("cnt_restart", underrun_cnt_o, 16'd0);
    idle(2);
    for (int i = 0; i < 65541; i++) cycle(1'b0, 1'b0, 1'b1);
    check("cnt_saturate", underrun_cnt_o, 16'hFFFF);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    idle(1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    valid_prob = 60;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++)
        if (q_size(k) == 0) begin
          int len;
          len = $urandom_range(3, 1);
          for (int j = 0; j < len; j++) q_push(k, $urandom(), j == len - 1);
        end
      cycle($urandom_range(9) == 0, $urandom_range(49) == 0, $urandom_range(3) == 0);
    end
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);
    idle(2);
    check("final_idle", busy_o, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pdm_playback_ctrl
